alu_decode_stage: RTL and testbench

- Decode/issue stage directly upstream of the ALU; feeds it alu_control, alu_src1 and alu_src2.
- Decodes one 32-bit MIPS-style integer instruction per transfer and reads operands from the register file.
- Registers the decoded ALU bundle in a single-entry pipeline register with a valid/ready handshake.
- Flags unsupported instructions as illegal.

---
 rtl/alu_decode_stage_if.sv | 28 ++
 rtl/alu_decode_stage.sv | 126 ++++++++++++
 tb/tb_alu_decode_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / ALU-bundle-out channel of the decode stage.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid && ready; the source holds its payload stable until then.
interface alu_decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [4:0]        dest;
    logic              rf_wen;
    logic              illegal;

    modport slave (
        input  in_valid, inst, out_ready,
        output in_ready, out_valid, alu_control, alu_src1, alu_src2, dest, rf_wen, illegal
    );

    modport master (
        output in_valid, inst, out_ready,
        input  in_ready, out_valid, alu_control, alu_src1, alu_src2, dest, rf_wen, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Decode/issue stage: decodes one MIPS-style integer instruction per beat, reads rs/rt and
// registers a one-hot ALU bundle in a single-entry pipeline register.
module alu_decode_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    alu_decode_stage_if.slave bus,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt;

    logic              dec_hit;
    logic [3:0]        dec_idx;
    logic [DATA_W-1:0] dec_src1;
    logic [DATA_W-1:0] dec_src2;
    logic [4:0]        dec_dest;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              load;

    assign opcode    = bus.inst[31:26];
    assign funct     = bus.inst[5:0];
    assign imm       = bus.inst[15:0];
    assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
    assign shamt     = {{(DATA_W-5){1'b0}}, bus.inst[10:6]};
    assign rf_raddr1 = bus.inst[25:21];
    assign rf_raddr2 = bus.inst[20:16];

    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = OP_ADD;
        dec_src1 = '0;
        dec_src2 = '0;
        dec_dest = '0;
        case (opcode)
            6'h00: begin
                dec_hit  = 1'b1;
                dec_src1 = rf_rdata1;
                dec_src2 = rf_rdata2;
                dec_dest = bus.inst[15:11];
                case (funct)
                    6'h21:   dec_idx = OP_ADD;
                    6'h23:   dec_idx = OP_SUB;
                    6'h2A:   dec_idx = OP_SLT;
                    6'h2B:   dec_idx = OP_SLTU;
                    6'h24:   dec_idx = OP_AND;
                    6'h27:   dec_idx = OP_NOR;
                    6'h25:   dec_idx = OP_OR;
                    6'h26:   dec_idx = OP_XOR;
                    6'h00:   begin dec_idx = OP_SLL; dec_src1 = shamt; end
                    6'h02:   begin dec_idx = OP_SRL; dec_src1 = shamt; end
                    6'h03:   begin dec_idx = OP_SRA; dec_src1 = shamt; end
                    default: dec_hit = 1'b0;
                endcase
            end
            6'h09: begin dec_hit = 1'b1; dec_idx = OP_ADD;  dec_src1 = rf_rdata1; dec_src2 = imm_sext; end
            6'h0A: begin dec_hit = 1'b1; dec_idx = OP_SLT;  dec_src1 = rf_rdata1; dec_src2 = imm_sext; end
            6'h0B: begin dec_hit = 1'b1; dec_idx = OP_SLTU; dec_src1 = rf_rdata1; dec_src2 = imm_sext; end
            6'h0C: begin dec_hit = 1'b1; dec_idx = OP_AND;  dec_src1 = rf_rdata1; dec_src2 = imm_zext; end
            6'h0D: begin dec_hit = 1'b1; dec_idx = OP_OR;   dec_src1 = rf_rdata1; dec_src2 = imm_zext; end
            6'h0E: begin dec_hit = 1'b1; dec_idx = OP_XOR;  dec_src1 = rf_rdata1; dec_src2 = imm_zext; end
            // LUI only forwards the immediate; the ALU does the 16-bit shift.
            6'h0F: begin dec_hit = 1'b1; dec_idx = OP_LUI;  dec_src2 = imm_zext; end
            default: dec_hit = 1'b0;
        endcase
        if (opcode != 6'h00) begin
            dec_dest = bus.inst[20:16];
        end
        if (!dec_hit) begin
            dec_src1 = '0;
            dec_src2 = '0;
            dec_dest = '0;
        end
    end

    // A single set bit from the index keeps alu_control one-hot by construction.
    assign dec_ctrl = dec_hit ? (CTRL_W'(1) << dec_idx) : '0;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.alu_control <= '0;
            bus.alu_src1    <= '0;
            bus.alu_src2    <= '0;
            bus.dest        <= '0;
            bus.rf_wen      <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (load) begin
            bus.out_valid   <= 1'b1;
            bus.alu_control <= dec_ctrl;
            bus.alu_src1    <= dec_src1;
            bus.alu_src2    <= dec_src2;
            bus.dest        <= dec_dest;
            bus.rf_wen      <= dec_hit && (dec_dest != 5'd0);
            bus.illegal     <= !dec_hit;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed test-plan cases plus random traffic, checked by a
// table-driven instruction model through an expected-bundle queue.
module tb_alu_decode_stage;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 12;
    localparam int BW     = CTRL_W + 2*DATA_W + 5 + 2;

    // Kinds: 0 reg-reg, 1 shift, 2 sign-ext imm, 3 zero-ext imm, 4 lui
    localparam logic [5:0] TBL_OP [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                           6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                           6'h0E, 6'h0F};
    localparam logic [5:0] TBL_FN [18] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h27, 6'h25, 6'h26,
                                           6'h00, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                           6'h00, 6'h00};
    localparam int TBL_BIT [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 2, 3, 4, 6, 7, 11};
    localparam int TBL_KND [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4};

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        rf_raddr1;
    logic [4:0]        rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    alu_decode_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    alu_decode_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] model(input logic [31:0] w, input logic [31:0] r1,
                                             input logic [31:0] r2);
        int               hit;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       s1;
        logic [31:0]       s2;
        logic [4:0]        d;
        hit = -1;
        for (int i = 0; i < 18; i++) begin
            if (w[31:26] == TBL_OP[i] && (w[31:26] != 6'h00 || w[5:0] == TBL_FN[i])) hit = i;
        end
        if (hit < 0) return {{CTRL_W{1'b0}}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
        ctrl = '0;
        ctrl[TBL_BIT[hit]] = 1'b1;
        s1 = r1;
        s2 = r2;
        d  = (w[31:26] == 6'h00) ? w[15:11] : w[20:16];
        case (TBL_KND[hit])
            1: s1 = 32'(w[10:6]);
            2: s2 = 32'($signed(w[15:0]));
            3: s2 = 32'(w[15:0]);
            4: begin s1 = 32'd0; s2 = 32'(w[15:0]); end
            default: ;
        endcase
        return {ctrl, s1, s2, d, d != 5'd0, 1'b0};
    endfunction

    // Expected bundles are queued just before the edge that loads them.
    always @(posedge clk) begin
        #4;
        if (reset) exp_q.delete();
        else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.inst, rf_rdata1, rf_rdata2));
    end

    always @(posedge clk) begin
        logic exp_valid;
        #2;
        if (!reset) begin
            exp_valid = exp_q.size() != 0;
            check("rf_raddr1", 128'(rf_raddr1), 128'(bus.inst[25:21]));
            check("rf_raddr2", 128'(rf_raddr2), 128'(bus.inst[20:16]));
            check("out_valid", 128'(bus.out_valid), 128'(exp_valid));
            check("in_ready", 128'(bus.in_ready), 128'(!exp_valid || bus.out_ready));
            if (bus.out_valid && exp_valid) begin
                check("bundle", 128'({bus.alu_control, bus.alu_src1, bus.alu_src2, bus.dest,
                                      bus.rf_wen, bus.illegal}), 128'(exp_q[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.inst     = w;
        rf_rdata1    = r1;
        rf_rdata2    = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, "_ctrl"}, 128'(bus.alu_control), 128'(0));
        check({tag, "_src1"}, 128'(bus.alu_src1), 128'(0));
        check({tag, "_src2"}, 128'(bus.alu_src2), 128'(0));
        check({tag, "_dest"}, 128'(bus.dest), 128'(0));
        check({tag, "_wen"}, 128'(bus.rf_wen), 128'(0));
        check({tag, "_illegal"}, 128'(bus.illegal), 128'(0));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            k = $urandom_range(0, 17);
            w[31:26] = TBL_OP[k];
            if (TBL_OP[k] == 6'h00) w[5:0] = TBL_FN[k];
            if ($urandom_range(0, 7) == 0) begin
                w[20:16] = 5'd0;
                w[15:11] = 5'd0;
            end
        end
        return w;
    endfunction

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.inst      = '0;
        bus.out_ready = 1'b1;
        rf_rdata1     = '0;
        rf_rdata2     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("reset");

        issue(32'h00221821, 32'h00001111, 32'h00001111);
        check("addu_ctrl", 128'(bus.alu_control), 128'(12'h001));
        check("addu_src1", 128'(bus.alu_src1), 128'(32'h00001111));
        check("addu_src2", 128'(bus.alu_src2), 128'(32'h00001111));
        check("addu_dest", 128'(bus.dest), 128'(3));
        check("addu_wen", 128'({bus.out_valid, bus.rf_wen, bus.illegal}), 128'(3'b110));
        issue(32'h2425FFFF, 32'h00000010, 32'h0);
        check("addiu_ctrl", 128'(bus.alu_control), 128'(12'h001));
        check("addiu_src", 128'({bus.alu_src1, bus.alu_src2}), 128'({32'h10, 32'hFFFFFFFF}));
        check("addiu_dest", 128'(bus.dest), 128'(5));
        issue(32'h3425FFFF, 32'h00000010, 32'h0);
        check("ori_ctrl", 128'(bus.alu_control), 128'(12'h040));
        check("ori_src2", 128'(bus.alu_src2), 128'(32'h0000FFFF));
        issue(32'h000220C3, 32'h0, 32'h80000000);
        check("sra_ctrl", 128'(bus.alu_control), 128'(12'h400));
        check("sra_src", 128'({bus.alu_src1, bus.alu_src2}), 128'({32'd3, 32'h80000000}));
        check("sra_dest", 128'(bus.dest), 128'(4));
        issue(32'h3C071234, 32'hDEADBEEF, 32'h0);
        check("lui_ctrl", 128'(bus.alu_control), 128'(12'h800));
        check("lui_src", 128'({bus.alu_src1, bus.alu_src2}), 128'({32'd0, 32'h00001234}));
        check("lui_dest", 128'(bus.dest), 128'(7));
        issue(32'hFC000000, 32'h12345678, 32'h9ABCDEF0);
        check("illegal_flags", 128'({bus.out_valid, bus.illegal, bus.rf_wen}), 128'(3'b110));
        check("illegal_ctrl", 128'(bus.alu_control), 128'(0));

        issue(32'h00221821, 32'h5, 32'h6);
        bus.out_ready = 1'b0;
        bus.inst      = 32'h00221823;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
            check("stall_ctrl", 128'(bus.alu_control), 128'(12'h001));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("subu_ctrl", 128'(bus.alu_control), 128'(12'h002));
        check("subu_valid", 128'(bus.out_valid), 128'(1));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", 128'(bus.out_valid), 128'(0));

        issue(32'h00221821, 32'h7, 32'h8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("held_valid", 128'(bus.out_valid), 128'(1));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_zero_outputs("midreset");

        bus.out_ready = 1'b1;
        issue(32'h00000000, $urandom, $urandom);
        check("nop_ctrl", 128'(bus.alu_control), 128'(12'h100));
        check("nop_flags", 128'({bus.out_valid, bus.rf_wen, bus.illegal}), 128'(3'b100));
        bus.in_valid = 1'b0;

        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            reset         = ($urandom_range(0, 99) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.inst      = rand_inst();
            rf_rdata1     = $urandom;
            rf_rdata2     = $urandom;
        end

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #3;
        check("final_drain", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
